apb_cmd_master: RTL
===================

// Module: apb_cmd_master
// PURPOSE
//  - Bridges a valid/ready command/response port onto the APB master side of apb_if.
//  - One transfer in flight; drives PADDR/PWDATA/PSEL/PENABLE/PWRITE, samples PRDATA/PREADY/PSLVERR.
//  - Sits directly upstream of the APB slaves; decodes a one-hot PSEL[15:0] from the address.
// PARAMETERS
//  - NUM_SLV      16   populated slave count (1..16); PSEL bits >= NUM_SLV are never driven high
//  - SLV_SEL_LSB  12   slave index = cmd_addr[SLV_SEL_LSB +: 4]
//  - TIMEOUT      255  max ACCESS cycles without PREADY (used only with APB_MST_TIMEOUT_EN)
// PORTS
//  - PCLK        in   1   clock; all logic is on its rising edge
//  - PRESETn     in   1   synchronous, active-low reset
//  - cmd_valid   in   1   command present
//  - cmd_ready   out  1   command accepted when valid&ready
//  - cmd_write   in   1   1 = write, 0 = read
//  - cmd_addr    in   32  byte address
//  - cmd_wdata   in   32  write data
//  - rsp_valid   out  1   response present
//  - rsp_ready   in   1   response consumed when valid&ready
//  - rsp_rdata   out  32  read data (0 for writes and errors)
//  - rsp_err     out  1   PSLVERR, decode error or timeout
//  - PADDR       out  32  APB address
//  - PWDATA      out  32  APB write data
//  - PSEL        out  16  APB one-hot select
//  - PENABLE     out  1   APB enable
//  - PWRITE      out  1   APB direction
//  - PRDATA      in   32  APB read data
//  - PREADY      in   1   APB ready
//  - PSLVERR     in   1   APB slave error
// BEHAVIOUR
//  - Reset (PRESETn=0 at an edge): state=IDLE; PADDR, PWDATA, PSEL, rsp_rdata = 0;
//    PENABLE, PWRITE, rsp_valid, rsp_err = 0.
//  - cmd_ready = (state==IDLE) & PRESETn; it is combinational and has no dependency on cmd_valid.
//  - FSM states are IDLE, SETUP, ACCESS and RESP.
//  - IDLE: on cmd_valid&cmd_ready, register addr, wdata (0 for reads) and write.
//    - If index < NUM_SLV, go to SETUP.
//    - Else (decode error) go to RESP with rsp_err=1 and rsp_rdata=0. No PSEL bit is asserted.
//  - SETUP: PSEL[index]=1, PENABLE=0. Unconditionally go to ACCESS the next cycle.
//  - ACCESS: PSEL held and PENABLE=1. On the edge where PREADY=1:
//    - capture rsp_err=PSLVERR;
//    - capture rsp_rdata=PRDATA only for an error-free read, else 0;
//    - clear PSEL and PENABLE, then go to RESP.
//  - RESP: rsp_valid=1, with rsp_rdata and rsp_err stable until rsp_ready. Then go to IDLE and drop rsp_valid.
//  - PADDR, PWDATA and PWRITE are stable from SETUP through the end of ACCESS. PADDR and PWRITE hold their last values in IDLE.
//  - Latency: accept at edge 0, SETUP cycle 1, ACCESS cycle 2.
//    - Zero-wait slave: rsp_valid high in cycle 3.
//    - Each PREADY-low cycle adds 1. Min command-to-command spacing is 4 cycles.
//  - Back-to-back: cmd_ready stays low from acceptance until the response handshake completes.
//  - PREADY, PRDATA and PSLVERR are ignored outside ACCESS.
//  - Reset mid-transfer: the next edge forces reset values. The in-flight command is dropped and no response is issued.
// CONFIGURATION
//  - APB_MST_TIMEOUT_EN defined:
//    - an 8-bit counter clears on entering ACCESS and increments each ACCESS cycle with PREADY=0;
//    - when it reaches TIMEOUT, clear PSEL/PENABLE, go to RESP with rsp_err=1 and rsp_rdata=0.
//  - APB_MST_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely for PREADY.
// TESTING
//  - Write 0x0000_3010/0xDEADBEEF, PREADY=1:
//    - PSEL=16'h0008 for 2 cycles; PENABLE only in the 2nd; PWRITE=1;
//    - rsp_valid in cycle 3 with err=0 and rdata=0.
//  - Read 0x0000_5004, 3 PREADY-low wait cycles, then PRDATA=0x1234_5678: rsp_rdata=0x1234_5678 in cycle 6, err=0.
//  - Read with PSLVERR=1 at PREADY: rsp_err=1 and rsp_rdata=0.
//  - NUM_SLV=4, addr 0x0000_7000: PSEL never leaves 0; rsp_valid the cycle after accept; err=1.
//  - Hold rsp_ready=0 for 5 cycles: rsp_valid and data held stable and cmd_ready=0 throughout; then IDLE the cycle after the handshake.
//  - PRESETn=0 during ACCESS: the next cycle has all APB outputs 0 and no rsp_valid.
//  - With APB_MST_TIMEOUT_EN, TIMEOUT=8 and PREADY stuck at 0: abort after 8 wait cycles with rsp_err=1.

Source files
------------

// File: rtl/apb_cmd_master_if.sv
// Bundles the command/response port and the APB master-side signals of apb_cmd_master.
// The master modport is the bridge's view. The slave modport is the opposite view, for
// whatever drives commands and models the APB slaves.
interface apb_cmd_master_if;
  // Command / response channel
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // APB bus
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [15:0] PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output PADDR, PWDATA, PSEL, PENABLE, PWRITE
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PADDR, PWDATA, PSEL, PENABLE, PWRITE
  );
endinterface

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: bridges a valid/ready command/response port onto an APB master.
// Only one transfer is in flight at a time. A one-hot PSEL[15:0] is decoded from
// cmd_addr[SLV_SEL_LSB +: 4]. An index >= NUM_SLV never touches the bus and returns an
// error response.
// Optional feature: define APB_MST_TIMEOUT_EN to abort an ACCESS phase that has seen
// TIMEOUT cycles without PREADY. The abort returns an error response.
module apb_cmd_master #(
  parameter int unsigned NUM_SLV     = 16,
  parameter int unsigned SLV_SEL_LSB = 12,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  apb_cmd_master_if.master bus
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e      r_state;
  logic [31:0] r_paddr;
  logic [31:0] r_pwdata;
  logic [15:0] r_psel;
  logic        r_penable;
  logic        r_pwrite;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

`ifdef APB_MST_TIMEOUT_EN
  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);
  logic [7:0] r_to_cnt;
`endif

  logic [3:0]  w_idx;
  logic        w_dec_ok;
  logic [15:0] w_sel_onehot;
  logic        w_accept;

  // Slave decode straight from the incoming command, so PSEL is valid in the SETUP cycle
  always_comb begin
    w_idx        = bus.cmd_addr[SLV_SEL_LSB +: 4];
    w_dec_ok     = (32'(w_idx) < NUM_SLV);
    w_sel_onehot = 16'd1 << w_idx;
  end

  // Ready only in IDLE, and forced low while reset is asserted
  assign bus.cmd_ready = (r_state == StIdle) & PRESETn;
  assign w_accept      = bus.cmd_valid & bus.cmd_ready;

  // Transfer FSM. Every bus and response output is a register.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state     <= StIdle;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_psel      <= '0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
`ifdef APB_MST_TIMEOUT_EN
      r_to_cnt    <= '0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_paddr  <= bus.cmd_addr;
            r_pwdata <= bus.cmd_write ? bus.cmd_wdata : 32'd0;
            r_pwrite <= bus.cmd_write;
            if (w_dec_ok) begin
              r_psel  <= w_sel_onehot;
              r_state <= StSetup;
            end else begin
              // Decode error: answer at once without touching the bus
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
              r_state     <= StResp;
            end
          end
        end

        StSetup: begin
          r_penable <= 1'b1;
`ifdef APB_MST_TIMEOUT_EN
          r_to_cnt  <= '0;
`endif
          r_state   <= StAccess;
        end

        StAccess: begin
          if (bus.PREADY) begin
            r_rsp_err   <= bus.PSLVERR;
            r_rsp_rdata <= (!r_pwrite && !bus.PSLVERR) ? bus.PRDATA : 32'd0;
            r_rsp_valid <= 1'b1;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_state     <= StResp;
          end
`ifdef APB_MST_TIMEOUT_EN
          else if (r_to_cnt + 8'd1 == TimeoutCnt) begin
            // This wait cycle brings the count to TIMEOUT: abandon the slave
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_valid <= 1'b1;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_state     <= StResp;
          end else begin
            r_to_cnt <= r_to_cnt + 8'd1;
          end
`endif
        end

        StResp: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.PADDR     = r_paddr;
  assign bus.PWDATA    = r_pwdata;
  assign bus.PSEL      = r_psel;
  assign bus.PENABLE   = r_penable;
  assign bus.PWRITE    = r_pwrite;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

endmodule
